// File: rtl/sap1_control_core.sv
// SAP-1 control core: instruction register, accumulator and six-state ring sequencer.
// Control lines are Moore outputs decoded from the current T-state and the IR opcode.
module sap1_control_core (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] ram_to_ir,
    input  logic [3:0] ram_to_a,
    output logic       Cp,
    output logic       Ep,
    output logic       Lmp,
    output logic       Lmi,
    output logic       Cei,
    output logic       Cea,
    output logic       Li,
    output logic       Ei,
    output logic       La,
    output logic       Ea,
    output logic       Su,
    output logic       Eu,
    output logic       Lb,
    output logic       Lo,
    output logic [3:0] ir_opcode,
    output logic [3:0] ir_operand,
    output logic [3:0] a_to_alu,
    output logic [3:0] a_bus
);

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    typedef enum logic [2:0] {T1, T2, T3, T4, T5, T6} state_t;

    state_t     r_state;
    logic       r_halt;
    logic [7:0] r_ir;
    logic [3:0] r_a;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= T1;
            r_halt  <= 1'b0;
            r_ir    <= 8'h00;
            r_a     <= 4'h0;
        end else if (!r_halt) begin
            if (Li)
                r_ir <= ram_to_ir;
            // ADD/SUB T6 asserts La with Eu: the ALU owns the write, A holds here
            if (La && !Eu)
                r_a <= ram_to_a;
            // HLT is seen on the bus while it is loaded, so the freeze starts at T4
            if (r_state == T3 && ram_to_ir[7:4] == OP_HLT)
                r_halt <= 1'b1;
            case (r_state)
                T1:      r_state <= T2;
                T2:      r_state <= T3;
                T3:      r_state <= T4;
                T4:      r_state <= T5;
                T5:      r_state <= T6;
                default: r_state <= T1;
            endcase
        end
    end

    always_comb begin
        Cp = 1'b0; Ep = 1'b0; Lmp = 1'b0; Lmi = 1'b0; Cei = 1'b0; Cea = 1'b0; Li = 1'b0;
        Ei = 1'b0; La = 1'b0; Ea = 1'b0; Su = 1'b0; Eu = 1'b0; Lb = 1'b0; Lo = 1'b0;
        if (!r_halt) begin
            case (r_state)
                T1: begin Ep = 1'b1; Lmp = 1'b1; end
                T2: Cp = 1'b1;
                T3: begin Cei = 1'b1; Li = 1'b1; end
                T4: begin
                    if (r_ir[7:4] == OP_LDA || r_ir[7:4] == OP_ADD || r_ir[7:4] == OP_SUB) begin
                        Ei = 1'b1; Lmi = 1'b1;
                    end else if (r_ir[7:4] == OP_OUT) begin
                        Ea = 1'b1; Lo = 1'b1;
                    end
                end
                T5: begin
                    if (r_ir[7:4] == OP_LDA) begin
                        Cea = 1'b1; La = 1'b1;
                    end else if (r_ir[7:4] == OP_ADD || r_ir[7:4] == OP_SUB) begin
                        Cea = 1'b1; Lb = 1'b1;
                    end
                end
                T6: begin
                    if (r_ir[7:4] == OP_ADD || r_ir[7:4] == OP_SUB) begin
                        Eu = 1'b1; La = 1'b1;
                        Su = (r_ir[7:4] == OP_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

    assign ir_opcode  = r_ir[7:4];
    assign ir_operand = Ei ? r_ir[3:0] : 4'b0000;
    assign a_to_alu   = r_a;
    assign a_bus      = Ea ? r_a : 4'b0000;

endmodule

// File: tb/tb_sap1_control_core.sv
// Bench for sap1_control_core: a T-step/opcode table model checked every cycle,
// plus directed literal expectations walking LDA, SUB, ADD, OUT, NOP, HLT and reset.
module tb_sap1_control_core;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] ram_to_ir = 8'h00;
    logic [3:0] ram_to_a = 4'h0;
    logic Cp, Ep, Lmp, Lmi, Cei, Cea, Li, Ei, La, Ea, Su, Eu, Lb, Lo;
    logic [3:0] ir_opcode, ir_operand, a_to_alu, a_bus;

    sap1_control_core dut (
        .clk(clk), .reset(reset), .ram_to_ir(ram_to_ir), .ram_to_a(ram_to_a),
        .Cp(Cp), .Ep(Ep), .Lmp(Lmp), .Lmi(Lmi), .Cei(Cei), .Cea(Cea), .Li(Li),
        .Ei(Ei), .La(La), .Ea(Ea), .Su(Su), .Eu(Eu), .Lb(Lb), .Lo(Lo),
        .ir_opcode(ir_opcode), .ir_operand(ir_operand), .a_to_alu(a_to_alu), .a_bus(a_bus)
    );

    always #5 clk = ~clk;

    // Control vector bit positions, Cp in the MSB down to Lo in the LSB
    localparam logic [13:0] CP = 14'h2000, EP = 14'h1000, LMP = 14'h0800, LMI = 14'h0400;
    localparam logic [13:0] CEI = 14'h0200, CEA = 14'h0100, LI = 14'h0080, EI = 14'h0040;
    localparam logic [13:0] LA = 14'h0020, EA = 14'h0010, SU = 14'h0008, EU = 14'h0004;
    localparam logic [13:0] LB = 14'h0002, LO = 14'h0001;

    logic [13:0] ctl;
    assign ctl = {Cp, Ep, Lmp, Lmi, Cei, Cea, Li, Ei, La, Ea, Su, Eu, Lb, Lo};

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: machine step 1..6, IR, A, halted
    int         m_step = 1;
    logic [7:0] m_ir = 8'h00;
    logic [3:0] m_a = 4'h0;
    bit         m_halt = 1'b0;

    function automatic logic [13:0] exp_ctl(input int step, input logic [3:0] op, input bit halted);
        logic [13:0] v;
        v = 14'h0;
        if (!halted) begin
            if (step == 1) v = EP | LMP;
            else if (step == 2) v = CP;
            else if (step == 3) v = CEI | LI;
            else if (step == 4) begin
                if (op <= 4'd2) v = EI | LMI;
                else if (op == 4'hE) v = EA | LO;
            end else if (step == 5) begin
                if (op == 4'h0) v = CEA | LA;
                else if (op == 4'h1 || op == 4'h2) v = CEA | LB;
            end else if (step == 6) begin
                if (op == 4'h1) v = EU | LA;
                else if (op == 4'h2) v = SU | EU | LA;
            end
        end
        return v;
    endfunction

    always @(posedge clk or negedge reset) begin
        logic [13:0] c;
        if (!reset) begin
            m_step = 1; m_ir = 8'h00; m_a = 4'h0; m_halt = 1'b0;
        end else if (!m_halt) begin
            c = exp_ctl(m_step, m_ir[7:4], m_halt);
            if (m_step == 3 && ram_to_ir[7:4] == 4'hF) m_halt = 1'b1;
            if ((c & LI) != 0) m_ir = ram_to_ir;
            if ((c & LA) != 0 && (c & EU) == 0) m_a = ram_to_a;
            m_step = (m_step % 6) + 1;
        end
    end

    always @(negedge clk) begin
        logic [13:0] e;
        if (chk_en) begin
            e = exp_ctl(m_step, m_ir[7:4], m_halt);
            chk("ctl", int'(ctl), int'(e));
            chk("ir_opcode", int'(ir_opcode), int'(m_ir[7:4]));
            chk("ir_operand", int'(ir_operand), ((e & EI) != 0) ? int'(m_ir[3:0]) : 0);
            chk("a_to_alu", int'(a_to_alu), int'(m_a));
            chk("a_bus", int'(a_bus), ((e & EA) != 0) ? int'(m_a) : 0);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        #2 reset = 1'b0;
        #1 chk_en = 1'b1;
        step(2);
        chk("rst_ctl", int'(ctl), int'(EP | LMP));
        chk("rst_ir", int'(ir_opcode), 0);
        chk("rst_a", int'(a_to_alu), 0);
        reset = 1'b1;
        // LDA 9
        ram_to_ir = 8'h09;
        step(3);
        chk("lda_t4_ctl", int'(ctl), int'(EI | LMI));
        chk("lda_t4_operand", int'(ir_operand), 9);
        ram_to_a = 4'hA;
        step(1);
        chk("lda_t5_ctl", int'(ctl), int'(CEA | LA));
        step(1);
        chk("lda_t6_a", int'(a_to_alu), 4'hA);
        chk("lda_t6_ctl", int'(ctl), 0);
        ram_to_a = 4'h3;
        step(1);
        chk("lda_t1_ctl", int'(ctl), int'(EP | LMP));
        // SUB C
        ram_to_ir = 8'h2C;
        step(3);
        chk("sub_t4_ctl", int'(ctl), int'(EI | LMI));
        chk("sub_t4_operand", int'(ir_operand), 4'hC);
        step(1);
        chk("sub_t5_ctl", int'(ctl), int'(CEA | LB));
        step(1);
        chk("sub_t6_ctl", int'(ctl), int'(SU | EU | LA));
        ram_to_a = 4'h5;
        step(1);
        chk("sub_a_hold", int'(a_to_alu), 4'hA);
        // ADD 3
        ram_to_ir = 8'h13;
        step(5);
        chk("add_t6_ctl", int'(ctl), int'(EU | LA));
        step(1);
        chk("add_a_hold", int'(a_to_alu), 4'hA);
        // OUT
        ram_to_ir = 8'hE0;
        step(3);
        chk("out_t4_ctl", int'(ctl), int'(EA | LO));
        chk("out_t4_bus", int'(a_bus), 4'hA);
        step(1);
        chk("out_t5_bus", int'(a_bus), 0);
        step(2);
        // Undefined opcode 7 behaves as NOP
        ram_to_ir = 8'h75;
        step(3);
        chk("nop_t4_ctl", int'(ctl), 0);
        chk("nop_t4_operand", int'(ir_operand), 0);
        step(3);
        chk("nop_t1_ctl", int'(ctl), int'(EP | LMP));
        // LDA interrupted by reset at T5: no load of A
        ram_to_ir = 8'h04;
        ram_to_a = 4'h6;
        step(4);
        chk("mid_t5_ctl", int'(ctl), int'(CEA | LA));
        reset = 1'b0;
        #1;
        chk("mid_rst_ctl", int'(ctl), int'(EP | LMP));
        chk("mid_rst_a", int'(a_to_alu), 0);
        step(1);
        chk("mid_rst_a_held", int'(a_to_alu), 0);
        reset = 1'b1;
        // LDA 6 then HLT
        ram_to_ir = 8'h01;
        step(5);
        chk("lda2_a", int'(a_to_alu), 4'h6);
        step(1);
        ram_to_ir = 8'hF0;
        step(3);
        chk("hlt_t4_ctl", int'(ctl), 0);
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk("hlt_frozen", int'(ctl), 0);
        end
        chk("hlt_a", int'(a_to_alu), 4'h6);
        #2 reset = 1'b0;
        #1;
        chk("hlt_rst_ctl", int'(ctl), int'(EP | LMP));
        chk("hlt_rst_ir", int'(ir_opcode), 0);
        chk("hlt_rst_a", int'(a_to_alu), 0);
        step(1);
        reset = 1'b1;
        ram_to_ir = 8'h00;
        step(1);
        chk("post_rst_ctl", int'(ctl), int'(CP));
        step(2);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sap1_control_core.md
Name: sap1_control_core

Overview:
- Combines the instruction register, the accumulator (A register) and the six-state control sequencer of an SAP-1-style 4-bit-address computer.
- Receives 8-bit instruction words and 4-bit data nibbles from RAM.
- Drives all machine control lines to the program counter, MAR, RAM, B register, ALU and output register.
- Exposes the IR operand field (for MAR addressing) and the A register contents (for the ALU and bus).

Parameters:
none (opcodes fixed: LDA=0000, ADD=0001, SUB=0010, OUT=1110, HLT=1111)

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-low; clears all state
ram_to_ir  input  8  instruction word from RAM ([7:4] opcode, [3:0] operand)
ram_to_a  input  4  data nibble from RAM for A register
Cp  output  1  PC increment
Ep  output  1  PC output enable
Lmp  output  1  MAR load from PC
Lmi  output  1  MAR load from IR operand
Cei  output  1  RAM enable toward IR
Cea  output  1  RAM enable toward A/B
Li  output  1  IR load
Ei  output  1  IR operand output enable
La  output  1  A register load
Ea  output  1  A register bus output enable
Su  output  1  ALU subtract select
Eu  output  1  ALU output enable
Lb  output  1  B register load
Lo  output  1  output register load
ir_opcode  output  4  IR[7:4], always driven
ir_operand  output  4  IR[3:0] when Ei=1, else 4'b0000
a_to_alu  output  4  A register contents, always driven
a_bus  output  4  A register contents when Ea=1, else 4'b0000

Behaviour:
- Reset (reset=0, asynchronous): sequencer to T1, IR=8'h00, A=4'h0, halt flag cleared.
- Control outputs are combinational from state (Moore); every line is 0 unless listed for the current state.
- Sequencer is a six-state ring T1→T2→T3→T4→T5→T6→T1, advancing one state per rising edge.
- While reset is held low, the sequencer stays in T1.
- Fetch, common to all opcodes:
  - T1: Ep, Lmp.
  - T2: Cp.
  - T3: Cei, Li.
- Execute, decoded from ir_opcode:
  - LDA (0000): T4 Ei, Lmi; T5 Cea, La; T6 none.
  - ADD (0001): T4 Ei, Lmi; T5 Cea, Lb; T6 Eu, La.
  - SUB (0010): T4 Ei, Lmi; T5 Cea, Lb; T6 Su, Eu, La.
  - OUT (1110): T4 Ea, Lo; T5, T6 none.
  - HLT (1111): on entering T4, set halt flag. While halted, the state is frozen and all controls are 0, until reset.
  - Undefined opcodes: T4–T6 behave as NOP.
- IR register: loads ram_to_ir on a rising edge with Li=1, otherwise holds.
  - The new opcode decodes from T4, after the T3 edge.
- A register: loads ram_to_a on a rising edge with La=1 and Eu=0.
  - When La=1 and Eu=1 (ADD/SUB T6), A holds; the external ALU result path writes through the bus. This block does not compute ALU results.
- Timing consequences:
  - Loaded values appear one cycle after the load signal becomes active.
  - An LDA instruction takes 6 cycles.
  - The value at address operand is visible on a_to_alu from T6 of that instruction.
- Reset asserted mid-instruction: immediate return to T1, all controls recompute to the T1 set, IR and A cleared; no partial load completes.
- Halted state survives all clock edges; only reset exits it.

Test Plan:
- Hold reset low, then release → Ep=1, Lmp=1, all other controls 0; ir_opcode=0000, a_to_alu=0000.
- Drive ram_to_ir=8'h09, then clock 3 edges → T4: ir_opcode=0000, Ei=1, Lmi=1, ir_operand=1001.
- Continue the same instruction with ram_to_a=4'hA during T5 → after the T5 edge a_to_alu=1010; T6 controls all 0; next edge returns to T1 (Ep=1, Lmp=1).
- Drive ram_to_ir=8'h2C at T3 → T4 Ei, Lmi; T5 Cea, Lb; T6 Su, Eu, La; A unchanged after T6.
- Drive ram_to_ir=8'hE0 at T3 with A=1010 → T4 Ea=1, Lo=1, a_bus=1010; a_bus=0000 in T5.
- Drive ram_to_ir=8'hF0 at T3 → all controls 0 for 10 further edges. Then assert reset low mid-cycle → immediate T1 with Ep=1, IR=00, A=0.
